dmac_ahb_slave_mem: RTL and testbench

- AHB-Lite responder: the target end of the DMA channel's master interface.
- Word-addressed memory that serves the channel's NONSEQ/SEQ read and write bursts, honours BUSY/IDLE, and inserts wait states programmable at run time.
- Returns the two-cycle ERROR response for illegal accesses.
- Used as source/destination memory in subsystem tests and as a generic on-chip scratch RAM behind the interconnect.

---
 rtl/dmac_ahb_slave_mem.sv | 124 ++++++++++++
 tb/tb_dmac_ahb_slave_mem.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmac_ahb_slave_mem.sv
// AHB-Lite word-addressed memory responder with run-time programmable wait
// states, two-cycle ERROR response for illegal accesses and wrapping
// transfer counters.
module dmac_ahb_slave_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 256,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  input  logic [3:0]        wait_cfg,
  output logic              HREADYOUT,
  output logic [1:0]        HRESP,
  output logic [DATA_W-1:0] HRDATA,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  err_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t            state;
  state_t            state_d;
  logic [IDX_W-1:0]  idx;
  logic              write_q;
  logic [3:0]        wcnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic accept;
  logic illegal;
  logic rd_done;
  logic wr_done;

  // HTRANS[0] only separates BUSY/SEQ from IDLE/NONSEQ, which does not
  // change how this responder treats a transfer.
  logic unused_trans0;
  assign unused_trans0 = HTRANS[0];

  // An address phase is only taken while this slave is itself ready, so the
  // held address during wait/error low cycles is never re-sampled.
  assign accept  = HSEL & HREADY & HTRANS[1] & HREADYOUT;
  assign illegal = ({2'b00, HADDR[ADDR_W-1:2]} >= ADDR_W'(DEPTH)) ||
                   (HADDR[1:0] != 2'b00) || (HSIZE != 3'b010);
  assign rd_done = (state == S_DATA) && !write_q;
  assign wr_done = (state == S_DATA) && write_q;

  // State, latched address phase, wait counter and transfer counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      write_q   <= 1'b0;
      wcnt      <= '0;
      rd_count  <= '0;
      wr_count  <= '0;
      err_count <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        idx     <= HADDR[IDX_W+1:2];
        write_q <= HWRITE;
        wcnt    <= wait_cfg;
      end else if (state == S_WAIT) begin
        wcnt <= wcnt - 4'd1;
      end
      if (rd_done) rd_count <= rd_count + CNT_W'(1);
      if (wr_done) wr_count <= wr_count + CNT_W'(1);
      if (state == S_ERR2) err_count <= err_count + CNT_W'(1);
    end
  end

  // Memory write commits at the edge that ends the write data phase
  always_ff @(posedge clk) begin
    if (wr_done) mem[idx] <= HWDATA;
  end

  // Next-state decode and bus response
  always_comb begin
    state_d   = state;
    HREADYOUT = 1'b1;
    HRESP     = 2'b00;
    HRDATA    = '0;
    case (state)
      S_WAIT: begin
        HREADYOUT = 1'b0;
        if (wcnt == 4'd1) state_d = S_DATA;
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 2'b01;
        state_d   = S_ERR2;
      end
      default: begin
        if (state == S_ERR2) HRESP = 2'b01;
        if (rd_done) HRDATA = mem[idx];
        state_d = S_IDLE;
      end
    endcase
    // Ready states double as the next address phase; ready is 1 here only
    // in S_IDLE, S_DATA and S_ERR2, so accept implies one of those.
    if (accept) begin
      if (illegal)              state_d = S_ERR1;
      else if (wait_cfg == '0)  state_d = S_DATA;
      else                      state_d = S_WAIT;
    end
  end

endmodule

// File: tb/tb_dmac_ahb_slave_mem.sv
// Directed self-checking bench for dmac_ahb_slave_mem.
module tb_dmac_ahb_slave_mem;

  logic        clk;
  logic        rst;
  logic        sel;
  logic [31:0] addr;
  logic [1:0]  trans;
  logic        write;
  logic [2:0]  size;
  logic [31:0] wdata;
  logic        hready;
  logic [3:0]  wcfg;
  logic        readyout;
  logic [1:0]  resp;
  logic [31:0] rdata;
  logic [15:0] rd_count;
  logic [15:0] wr_count;
  logic [15:0] err_count;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  dmac_ahb_slave_mem #(
    .DATA_W(32),
    .ADDR_W(32),
    .DEPTH (256),
    .CNT_W (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .HSEL     (sel),
    .HADDR    (addr),
    .HTRANS   (trans),
    .HWRITE   (write),
    .HSIZE    (size),
    .HWDATA   (wdata),
    .HREADY   (hready),
    .wait_cfg (wcfg),
    .HREADYOUT(readyout),
    .HRESP    (resp),
    .HRDATA   (rdata),
    .rd_count (rd_count),
    .wr_count (wr_count),
    .err_count(err_count)
  );

  // Single-slave bus: the bus-wide ready is this slave's ready
  assign hready = readyout;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [1:0] t, input logic w,
                       input logic [31:0] a, input logic [2:0] z, input logic [31:0] d);
    sel   = s;
    trans = t;
    write = w;
    addr  = a;
    size  = z;
    wdata = d;
    #1;
  endtask

  task automatic idle(input logic [31:0] d);
    drive(1'b0, T_IDLE, 1'b0, 32'h0, 3'b010, d);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] dv [4];
  logic [31:0] ea [3];
  logic [2:0]  ez [3];
  logic        ew [3];
  int unsigned lows;
  int unsigned total;

  initial begin
    dv = '{32'h1357_9BDF, 32'h2468_ACE0, 32'h0F0F_F0F0, 32'h8000_0001};
    ea = '{32'h0000_0400, 32'h0000_0006, 32'h0000_0010};
    ez = '{3'b010, 3'b010, 3'b001};
    ew = '{1'b0, 1'b0, 1'b1};

    rst  = 1'b0;
    wcfg = 4'd0;
    idle(32'h0);
    tick();
    tick();
    check("rst_ready", {31'h0, readyout}, 32'h1);
    check("rst_resp", {30'h0, resp}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_counts", {rd_count, wr_count | err_count}, 32'h0);
    rst = 1'b1;
    tick();

    // Zero-wait write then read of the same word
    drive(1'b1, T_NSEQ, 1'b1, 32'h10, 3'b010, 32'h0);
    check("wr_addr_ready", {31'h0, readyout}, 32'h1);
    tick();
    drive(1'b1, T_NSEQ, 1'b0, 32'h10, 3'b010, 32'hDEAD_BEEF);
    check("wr_data_ready", {31'h0, readyout}, 32'h1);
    tick();
    idle(32'h0);
    check("rd_after_wr", rdata, 32'hDEAD_BEEF);
    check("rd_data_ready", {31'h0, readyout}, 32'h1);
    tick();
    check("t1_counts", {rd_count, wr_count}, {16'd1, 16'd1});
    check("t1_idle_rdata", rdata, 32'h0);

    // Write burst 0x0..0xC with BUSY after beat 2, zero wait
    drive(1'b1, T_NSEQ, 1'b1, 32'h0, 3'b010, 32'h0);
    tick();
    drive(1'b1, T_SEQ, 1'b1, 32'h4, 3'b010, dv[0]);
    check("bw_beat0_ready", {31'h0, readyout}, 32'h1);
    tick();
    drive(1'b1, T_BUSY, 1'b1, 32'h8, 3'b010, dv[1]);
    check("bw_beat1_ready", {31'h0, readyout}, 32'h1);
    tick();
    drive(1'b1, T_SEQ, 1'b1, 32'h8, 3'b010, 32'h5555_5555);
    check("busy_ready", {31'h0, readyout}, 32'h1);
    check("busy_resp", {30'h0, resp}, 32'h0);
    check("busy_rdata", rdata, 32'h0);
    check("busy_wr_count", {16'h0, wr_count}, 32'd3);
    tick();
    drive(1'b1, T_SEQ, 1'b1, 32'hC, 3'b010, dv[2]);
    tick();
    idle(dv[3]);
    check("bw_beat3_ready", {31'h0, readyout}, 32'h1);
    tick();
    check("bw_wr_count", {16'h0, wr_count}, 32'd5);

    // 4-beat read burst with two wait states per beat
    wcfg = 4'd2;
    lows = 0;
    total = 0;
    drive(1'b1, T_NSEQ, 1'b0, 32'h0, 3'b010, 32'h0);
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k < 3) drive(1'b1, T_SEQ, 1'b0, 32'(4 * (k + 1)), 3'b010, 32'h0);
      else       idle(32'h0);
      for (int c = 0; c < 3; c++) begin
        total++;
        if (!readyout) lows++;
        if (c == 2) begin
          check($sformatf("wr_beat%0d_ready", k), {31'h0, readyout}, 32'h1);
          check($sformatf("wr_beat%0d_data", k), rdata, dv[k]);
        end else if (k == 0 && c == 0) begin
          check("wait_rdata", rdata, 32'h0);
        end
        tick();
      end
    end
    check("wait_low_cycles", lows, 32'd8);
    check("wait_total_cycles", total, 32'd12);
    check("wait_rd_count", {16'h0, rd_count}, 32'd5);
    wcfg = 4'd0;

    // Illegal accesses: out of range, misaligned, wrong size (write)
    for (int e = 0; e < 3; e++) begin
      drive(1'b1, T_NSEQ, ew[e], ea[e], ez[e], 32'h0);
      tick();
      idle(32'h1234_5678);
      check($sformatf("err%0d_c1", e), {29'h0, readyout, resp}, {29'h0, 1'b0, 2'b01});
      tick();
      idle(32'h1234_5678);
      check($sformatf("err%0d_c2", e), {29'h0, readyout, resp}, {29'h0, 1'b1, 2'b01});
      tick();
      check($sformatf("err%0d_after", e), {29'h0, readyout, resp}, {29'h0, 1'b1, 2'b00});
      check($sformatf("err%0d_count", e), {16'h0, err_count}, 32'(e + 1));
    end
    drive(1'b1, T_NSEQ, 1'b0, 32'h10, 3'b010, 32'h0);
    tick();
    idle(32'h0);
    check("err_mem_unchanged", rdata, 32'hDEAD_BEEF);
    tick();
    check("err_rd_wr_counts", {rd_count, wr_count}, {16'd6, 16'd5});

    // Reset in the 3rd wait cycle of a 5-wait write
    drive(1'b1, T_NSEQ, 1'b1, 32'h20, 3'b010, 32'h0);
    tick();
    idle(32'h0BAD_F00D);
    tick();
    idle(32'h0);
    wcfg = 4'd5;
    drive(1'b1, T_NSEQ, 1'b1, 32'h20, 3'b010, 32'h0);
    tick();
    wcfg = 4'd0;
    idle(32'hCAFE_F00D);
    check("rw_wait1", {31'h0, readyout}, 32'h0);
    tick();
    idle(32'hCAFE_F00D);
    check("rw_wait2", {31'h0, readyout}, 32'h0);
    tick();
    idle(32'hCAFE_F00D);
    rst = 1'b0;
    #1;
    check("rst_mid_ready_resp", {29'h0, readyout, resp}, {29'h0, 1'b1, 2'b00});
    check("rst_mid_counts", {rd_count, wr_count}, 32'h0);
    check("rst_mid_err", {16'h0, err_count}, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    drive(1'b1, T_NSEQ, 1'b0, 32'h20, 3'b010, 32'h0);
    tick();
    idle(32'h0);
    check("rst_word_kept", rdata, 32'h0BAD_F00D);
    tick();

    // Unselected NONSEQ is ignored
    drive(1'b0, T_NSEQ, 1'b1, 32'h20, 3'b010, 32'h0);
    check("nosel_ready", {31'h0, readyout}, 32'h1);
    tick();
    drive(1'b0, T_IDLE, 1'b0, 32'h0, 3'b010, 32'hFFFF_FFFF);
    check("nosel_ready2", {31'h0, readyout}, 32'h1);
    check("nosel_rdata", rdata, 32'h0);
    tick();
    check("nosel_wr_count", {16'h0, wr_count}, 32'd0);
    drive(1'b1, T_NSEQ, 1'b0, 32'h20, 3'b010, 32'h0);
    tick();
    idle(32'h0);
    check("nosel_word_kept", rdata, 32'h0BAD_F00D);
    tick();

    // 65536 back-to-back writes wrap the write counter
    for (int i = 0; i < 65536; i++) begin
      drive(1'b1, T_NSEQ, 1'b1, 32'((i % 256) * 4), 3'b010, 32'(i - 1));
      tick();
    end
    idle(32'd65535);
    check("wrap_ready", {31'h0, readyout}, 32'h1);
    check("wrap_ffff", {16'h0, wr_count}, 32'h0000_FFFF);
    tick();
    check("wrap_zero", {16'h0, wr_count}, 32'h0);
    drive(1'b1, T_NSEQ, 1'b0, 32'h3FC, 3'b010, 32'h0);
    tick();
    idle(32'h0);
    check("wrap_last_word", rdata, 32'd65535);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
